// File: rtl/arp_tx_sched.sv
// arp_tx_sched: sequences the ARP header writer and the Ethernet transmit path.
//
// Queues ARP reply requests from the RX parser, programs the local IP into the writer
// on demand, and for each queued request drives one writer operation, waits for
// completion, then requests, holds and releases the transmit port. The writer never
// sees overlapping operations.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_req_valid/i_req_mac/i_req_ip  reply request from RX parser
//   o_req_ready                     queue not full
//   i_local_set/i_local_ip          local IP load request (rising edge) and value
//   o_wr_trig/o_wr_set_local        writer destination / local-IP trigger pulses
//   o_wr_mac/o_wr_ip                address buses to writer
//   i_wr_ready                      writer completion pulse
//   o_tx_req/i_tx_gnt/i_tx_done     transmit request handshake
//   o_busy, o_err, o_drop_cnt       status
//
// Optional feature macro: ARP_SCHED_DEDUP_EN discards pushes whose IP matches a queued
// or in-flight request (not counted as drops).

module arp_tx_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WR_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic [47:0] i_req_mac,
  input  logic [31:0] i_req_ip,
  output logic        o_req_ready,
  input  logic        i_local_set,
  input  logic [31:0] i_local_ip,
  output logic        o_wr_trig,
  output logic        o_wr_set_local,
  output logic [47:0] o_wr_mac,
  output logic [31:0] o_wr_ip,
  input  logic        i_wr_ready,
  output logic        o_tx_req,
  input  logic        i_tx_gnt,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_err,
  output logic [7:0]  o_drop_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(WR_TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StLocTrig, StLocWait, StLoad, StDstTrig, StDstWait, StGap, StTxReq, StTxWait
  } state_e;

  state_e         state_q, state_d;
  logic [47:0]    fifo_mac_q [FIFO_DEPTH];
  logic [31:0]    fifo_ip_q  [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           req_ready_q;
  logic [7:0]     drop_q;
  logic           local_prev_q, local_pend_q, local_pend_d;
  logic [31:0]    local_ip_q;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           tmo_fire;
  logic           wr_trig_q, set_local_q, tx_req_q, busy_q, err_q;
  logic [47:0]    wr_mac_q;
  logic [31:0]    wr_ip_q;

  logic push, pop, drop, dup, local_rise, loc_enter;

  assign drop       = i_req_valid & ~req_ready_q;
  assign push       = i_req_valid & req_ready_q & ~dup;
  assign pop        = (state_q == StIdle) & ~local_pend_q & (count_q != '0);
  assign local_rise = i_local_set & ~local_prev_q;
  assign loc_enter  = (state_q == StIdle) & (state_d == StLocTrig);

`ifdef ARP_SCHED_DEDUP_EN
  logic inflight;
  assign inflight = (state_q == StLoad)    | (state_q == StDstTrig) | (state_q == StDstWait) |
                    (state_q == StGap)     | (state_q == StTxReq)   | (state_q == StTxWait);

  // An entry is valid when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [AW-1:0] offs;
    dup = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      offs = AW'(i) - rd_ptr_q;
      if ((CW'(offs) < count_q) && (fifo_ip_q[i] == i_req_ip)) dup = 1'b1;
    end
    if (inflight && (wr_ip_q == i_req_ip)) dup = 1'b1;
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next state and writer timeout.
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (local_pend_q)          state_d = StLocTrig;
        else if (count_q != '0)    state_d = StLoad;
      end
      StLocTrig: state_d = StLocWait;
      StLocWait: begin
        if (i_wr_ready) state_d = StIdle;
        else if (tmo_q == TW'(WR_TIMEOUT - 1)) begin
          tmo_fire = 1'b1;
          state_d  = StIdle;
        end
      end
      StLoad:    state_d = StDstTrig;
      StDstTrig: state_d = StDstWait;
      StDstWait: begin
        if (i_wr_ready) state_d = StGap;
        else if (tmo_q == TW'(WR_TIMEOUT - 1)) begin
          // Request is abandoned; no transmit for it.
          tmo_fire = 1'b1;
          state_d  = StIdle;
        end
      end
      StGap:     state_d = StTxReq;
      StTxReq:   if (i_tx_gnt) state_d = StTxWait;
      StTxWait:  if (i_tx_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    tmo_d = '0;
    if (((state_q == StLocWait) || (state_q == StDstWait)) && (state_d == state_q)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // A fresh edge wins over the clear so its IP is not lost.
  always_comb begin
    local_pend_d = local_pend_q;
    if (local_rise)     local_pend_d = 1'b1;
    else if (loc_enter) local_pend_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      req_ready_q  <= 1'b1;
      drop_q       <= '0;
      local_prev_q <= 1'b0;
      local_pend_q <= 1'b0;
      local_ip_q   <= '0;
      tmo_q        <= '0;
      wr_trig_q    <= 1'b0;
      set_local_q  <= 1'b0;
      tx_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_mac_q     <= '0;
      wr_ip_q      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mac_q[i] <= '0;
        fifo_ip_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      req_ready_q  <= (count_d != CW'(FIFO_DEPTH));
      local_prev_q <= i_local_set;
      local_pend_q <= local_pend_d;
      tmo_q        <= tmo_d;
      wr_trig_q    <= (state_d == StDstTrig);
      set_local_q  <= (state_d == StLocTrig);
      tx_req_q     <= (state_d == StTxReq);
      busy_q       <= (state_d != StIdle);
      err_q        <= err_q | tmo_fire;
      if (local_rise) local_ip_q <= i_local_ip;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      if (push) begin
        fifo_mac_q[wr_ptr_q] <= i_req_mac;
        fifo_ip_q[wr_ptr_q]  <= i_req_ip;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      // Pop coincides with IDLE -> LOAD; buses are stable before the trigger.
      if (pop) begin
        wr_mac_q <= fifo_mac_q[rd_ptr_q];
        wr_ip_q  <= fifo_ip_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else if (loc_enter) begin
        wr_ip_q  <= local_ip_q;
      end
    end
  end

  assign o_req_ready    = req_ready_q;
  assign o_wr_trig      = wr_trig_q;
  assign o_wr_set_local = set_local_q;
  assign o_wr_mac       = wr_mac_q;
  assign o_wr_ip        = wr_ip_q;
  assign o_tx_req       = tx_req_q;
  assign o_busy         = busy_q;
  assign o_err          = err_q;
  assign o_drop_cnt     = drop_q;

endmodule

// File: tb/tb_arp_tx_sched.sv
// Self-checking bench for arp_tx_sched: directed vector table plus hand-written
// multi-cycle sequences. A responder process models the writer and TX sender.

module tb_arp_tx_sched;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic [47:0] i_req_mac = '0;
  logic [31:0] i_req_ip = '0;
  logic        o_req_ready;
  logic        i_local_set = 1'b0;
  logic [31:0] i_local_ip = '0;
  logic        o_wr_trig, o_wr_set_local;
  logic [47:0] o_wr_mac;
  logic [31:0] o_wr_ip;
  logic        i_wr_ready, i_tx_gnt, i_tx_done;
  logic        o_tx_req, o_busy, o_err;
  logic [7:0]  o_drop_cnt;

  always #5 i_clk = ~i_clk;

  arp_tx_sched #(.FIFO_DEPTH(4), .WR_TIMEOUT(64)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .i_req_mac     (i_req_mac),
    .i_req_ip      (i_req_ip),
    .o_req_ready   (o_req_ready),
    .i_local_set   (i_local_set),
    .i_local_ip    (i_local_ip),
    .o_wr_trig     (o_wr_trig),
    .o_wr_set_local(o_wr_set_local),
    .o_wr_mac      (o_wr_mac),
    .o_wr_ip       (o_wr_ip),
    .i_wr_ready    (i_wr_ready),
    .o_tx_req      (o_tx_req),
    .i_tx_gnt      (i_tx_gnt),
    .i_tx_done     (i_tx_done),
    .o_busy        (o_busy),
    .o_err         (o_err),
    .o_drop_cnt    (o_drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Responder controls and monitors (updated at posedge+2).
  bit          wr_en = 1'b1, gnt_en = 1'b1, done_en = 1'b1;
  int          wr_delay = 10, done_delay = 3;
  int          n_trig = 0, n_setloc = 0, n_reply = 0, n_txreq = 0, n_pulse_bad = 0;
  logic [31:0] trig_ips[$];

  initial begin : responder
    int wr_cnt, done_cnt;
    bit prev_trig, prev_setl, prev_txreq;
    wr_cnt = 0; done_cnt = 0;
    prev_trig = 0; prev_setl = 0; prev_txreq = 0;
    i_wr_ready = 1'b0; i_tx_gnt = 1'b0; i_tx_done = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      i_wr_ready = 1'b0; i_tx_gnt = 1'b0; i_tx_done = 1'b0;
      if (!i_rst_n) begin
        wr_cnt = 0; done_cnt = 0;
        prev_trig = 0; prev_setl = 0; prev_txreq = 0;
        continue;
      end
      if (o_wr_trig) begin
        n_trig++;
        trig_ips.push_back(o_wr_ip);
      end
      if (o_wr_set_local) n_setloc++;
      if ((o_wr_trig && prev_trig) || (o_wr_set_local && prev_setl)) n_pulse_bad++;
      if (o_tx_req && !prev_txreq) n_txreq++;
      prev_trig = o_wr_trig; prev_setl = o_wr_set_local; prev_txreq = o_tx_req;
      if ((o_wr_trig || o_wr_set_local) && wr_en) wr_cnt = wr_delay;
      else if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) i_wr_ready = 1'b1;
      end
      if (o_tx_req && gnt_en) begin
        i_tx_gnt = 1'b1;
        n_reply++;
        if (done_en) done_cnt = done_delay;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) i_tx_done = 1'b1;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  function automatic bit cond(input int sel, input int tgt);
    case (sel)
      0:       return o_wr_trig;
      1:       return !o_busy;
      2:       return n_reply >= tgt;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int tgt, input int bound, input string name);
    int waited;
    waited = 0;
    while (!cond(sel, tgt) && waited < bound) begin
      cyc();
      waited++;
    end
    n_cmp++;
    if (!cond(sel, tgt)) begin
      n_bad++;
      $display("FAIL %s: condition still false after %0d cycles, expected true", name, bound);
    end
  endtask

  // Pushes during the current cycle; returns one cycle later.
  task automatic push(input logic [47:0] mac, input logic [31:0] ip);
    i_req_valid = 1'b1;
    i_req_mac   = mac;
    i_req_ip    = ip;
    cyc();
    i_req_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req_ready"}, o_req_ready, 1);
    chk({tag, " wr_trig"}, o_wr_trig, 0);
    chk({tag, " set_local"}, o_wr_set_local, 0);
    chk({tag, " wr_mac"}, o_wr_mac, 0);
    chk({tag, " wr_ip"}, o_wr_ip, 0);
    chk({tag, " tx_req"}, o_tx_req, 0);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " err"}, o_err, 0);
    chk({tag, " drop_cnt"}, o_drop_cnt, 0);
  endtask

  typedef struct {
    logic [47:0] mac;
    logic [31:0] ip;
    int          wr_dly;
    logic [47:0] exp_mac;
    logic [31:0] exp_ip;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs[3];
    logic [31:0] exp_ips[5];
    int          rep0, trig0, txq0, base, exp_rep;

    vecs[0] = '{48'hA0B0C0D0E0F0, 32'h0A000101, 1, 48'hA0B0C0D0E0F0, 32'h0A000101};
    vecs[1] = '{48'h020000000001, 32'hAC100002, 4, 48'h020000000001, 32'hAC100002};
    vecs[2] = '{48'hFFFFFFFFFFFE, 32'hFFFFFFFF, 7, 48'hFFFFFFFFFFFE, 32'hFFFFFFFF};

    // Reset values.
    cyc(3);
    chk_reset_vals("reset");
    i_rst_n = 1'b1;
    cyc(2);

    // Single request, writer ready 10 cycles after trigger, tx_req held until grant.
    wr_delay = 10; gnt_en = 1'b0;
    push(48'h001122334455, 32'hC0A8010A);          // now N+1
    chk("t1 busy N+1", o_busy, 0);
    cyc();                                          // N+2 LOAD
    chk("t1 busy LOAD", o_busy, 1);
    chk("t1 mac LOAD", o_wr_mac, 48'h001122334455);
    chk("t1 ip LOAD", o_wr_ip, 32'hC0A8010A);
    chk("t1 trig LOAD", o_wr_trig, 0);
    cyc();                                          // N+3
    chk("t1 trig N+3", o_wr_trig, 1);
    chk("t1 mac trig", o_wr_mac, 48'h001122334455);
    cyc();
    chk("t1 trig N+4", o_wr_trig, 0);
    cyc(10);                                        // N+14 GAP
    chk("t1 tx_req GAP", o_tx_req, 0);
    cyc();                                          // N+15
    chk("t1 tx_req M+2", o_tx_req, 1);
    cyc(5);
    chk("t1 tx_req held", o_tx_req, 1);
    gnt_en = 1'b1;                                  // granted this cycle (K)
    cyc();
    chk("t1 tx_req K+1", o_tx_req, 0);
    chk("t1 busy TX_WAIT", o_busy, 1);
    cyc(2);
    chk("t1 busy done cycle", o_busy, 1);
    cyc();
    chk("t1 busy idle", o_busy, 0);
    cyc(2);

    // Vector table: single requests with varied writer latency.
    for (int v = 0; v < 3; v++) begin
      wr_delay = vecs[v].wr_dly;
      push(vecs[v].mac, vecs[v].ip);
      cyc();
      chk($sformatf("vec%0d mac", v), o_wr_mac, vecs[v].exp_mac);
      chk($sformatf("vec%0d ip", v), o_wr_ip, vecs[v].exp_ip);
      cyc();
      chk($sformatf("vec%0d trig", v), o_wr_trig, 1);
      cyc(vecs[v].wr_dly + 1);
      chk($sformatf("vec%0d tx_req gap", v), o_tx_req, 0);
      cyc();
      chk($sformatf("vec%0d tx_req on", v), o_tx_req, 1);
      wait_for(1, 0, 20, $sformatf("vec%0d idle", v));
      cyc(2);
    end

    // Local-IP load has priority over a queued request.
    wr_delay = 4;
    i_local_set = 1'b1;
    i_local_ip  = 32'hC0A80102;
    push(48'h0A0B0C0D0E0F, 32'hC0A80164);            // E+1
    chk("t2 setl E+1", o_wr_set_local, 0);
    cyc();
    chk("t2 setl E+2", o_wr_set_local, 1);
    chk("t2 local ip", o_wr_ip, 32'hC0A80102);
    chk("t2 trig during local", o_wr_trig, 0);
    cyc();
    chk("t2 setl E+3", o_wr_set_local, 0);
    wait_for(0, 0, 20, "t2 trig after local");
    chk("t2 req ip", o_wr_ip, 32'hC0A80164);
    chk("t2 setloc count", n_setloc, 1);
    wait_for(1, 0, 30, "t2 idle");
    cyc(3);
    chk("t2 no re-trigger on level", n_setloc, 1);
    i_local_set = 1'b0;
    cyc(2);

    // Six back-to-back pushes while held in TX_REQ.
    gnt_en = 1'b0; wr_delay = 3;
    rep0 = n_reply; base = trig_ips.size();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3 ready push%0d", i), o_req_ready, (i == 5) ? 1'b0 : 1'b1);
      i_req_valid = 1'b1;
      i_req_mac   = 48'h0200000000A0 + 48'(i);
      i_req_ip    = 32'h0A00000A + 32'(i);
      cyc();
    end
    i_req_valid = 1'b0;
    chk("t3 drop", o_drop_cnt, 1);
    chk("t3 ready full", o_req_ready, 0);
    cyc(10);
    chk("t3 still full", o_req_ready, 0);
    chk("t3 tx_req held", o_tx_req, 1);
    gnt_en = 1'b1;
    wait_for(2, rep0 + 5, 300, "t3 five replies");
    wait_for(1, 0, 50, "t3 idle");
    exp_ips = '{32'h0A00000A, 32'h0A00000B, 32'h0A00000C, 32'h0A00000D, 32'h0A00000E};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3 order %0d", k),
          (trig_ips.size() > base + k) ? trig_ips[base + k] : 32'hDEADBEEF, exp_ips[k]);
    end
    cyc(5);
    chk("t3 reply count", n_reply - rep0, 5);
    chk("t3 ready after", o_req_ready, 1);

    // Writer timeout in DST_WAIT.
    wr_en = 1'b0;
    rep0 = n_reply; txq0 = n_txreq;
    push(48'h02000000BB01, 32'h0A000020);            // N
    push(48'h02000000BB02, 32'h0A000021);            // N+1
    cyc();                                           // T = N+3
    chk("t4 trig", o_wr_trig, 1);
    cyc(64);
    chk("t4 err before", o_err, 0);
    cyc();
    chk("t4 err set", o_err, 1);
    chk("t4 idle after timeout", o_busy, 0);
    wr_en = 1'b1;
    wait_for(2, rep0 + 1, 60, "t4 next request reply");
    wait_for(1, 0, 30, "t4 idle");
    cyc(3);
    chk("t4 tx_req count", n_txreq - txq0, 1);
    chk("t4 second ip", trig_ips[trig_ips.size() - 1], 32'h0A000021);
    chk("t4 err sticky", o_err, 1);

    // Reset during TX_WAIT with 3 queued.
    done_en = 1'b0; wr_delay = 2;
    rep0 = n_reply;
    for (int i = 0; i < 4; i++) push(48'h02000000CC00 + 48'(i), 32'h0A000030 + 32'(i));
    wait_for(2, rep0 + 1, 40, "t5 in TX_WAIT");
    chk("t5 busy TX_WAIT", o_busy, 1);
    trig0 = n_trig;
    i_rst_n = 1'b0;
    #1;
    chk_reset_vals("t5 async");
    cyc(2);
    i_rst_n = 1'b1;
    done_en = 1'b1;
    cyc(30);
    chk("t5 no trig after release", n_trig - trig0, 0);
    chk("t5 busy after release", o_busy, 0);
    chk("t5 tx_req after release", o_tx_req, 0);

    // Duplicate IP while the first is in flight.
`ifdef ARP_SCHED_DEDUP_EN
    exp_rep = 1;
`else
    exp_rep = 2;
`endif
    wr_delay = 3;
    rep0 = n_reply;
    push(48'h02000000DD01, 32'h0A000005);
    wait_for(0, 0, 10, "t6 first trig");
    push(48'h02000000DD02, 32'h0A000005);
    wait_for(2, rep0 + exp_rep, 100, "t6 replies");
    cyc(40);
    chk("t6 reply count", n_reply - rep0, exp_rep);
    chk("t6 drop", o_drop_cnt, 0);
    chk("pulse width violations", n_pulse_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
